// File: rtl/date_pkg.sv
// Shared types, BCD constants and date helpers for the date set-mode controller.
package date_pkg;

  localparam logic [2:0] S_RUN    = 3'd0;
  localparam logic [2:0] S_SET_YY = 3'd1;
  localparam logic [2:0] S_SET_MM = 3'd2;
  localparam logic [2:0] S_SET_DD = 3'd3;
  localparam logic [2:0] S_COMMIT = 3'd4;

  typedef enum logic [2:0] {
    RUN    = S_RUN,
    SET_YY = S_SET_YY,
    SET_MM = S_SET_MM,
    SET_DD = S_SET_DD,
    COMMIT = S_COMMIT
  } state_e;

  localparam logic [7:0] YY_MIN = 8'h00;
  localparam logic [7:0] YY_MAX = 8'h99;
  localparam logic [7:0] MM_MIN = 8'h01;
  localparam logic [7:0] MM_MAX = 8'h12;
  localparam logic [7:0] DD_MIN = 8'h01;
  localparam logic [7:0] D31    = 8'h31;
  localparam logic [7:0] D30    = 8'h30;
  localparam logic [7:0] D29    = 8'h29;
  localparam logic [7:0] D28    = 8'h28;

  localparam int FLD_YY = 2;
  localparam int FLD_MM = 1;
  localparam int FLD_DD = 0;

  function automatic logic bcd_ok(input logic [7:0] v);
    return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9);
  endfunction

  function automatic logic bcd_in_range(input logic [7:0] v, input logic [7:0] lo,
                                        input logic [7:0] hi);
    return bcd_ok(v) && (v >= lo) && (v <= hi);
  endfunction

  // Binary (10*hi + lo) mod 4 equals (2*hi + lo) mod 4, so no full conversion is needed.
  function automatic logic is_leap(input logic [7:0] yy);
    logic [4:0] s;
    s = {yy[7:4], 1'b0} + {1'b0, yy[3:0]};
    return s[1:0] == 2'b00;
  endfunction

  function automatic logic [7:0] maxday(input logic [7:0] mm, input logic [7:0] yy);
    logic [7:0] r;
    case (mm)
      8'h02:                      r = is_leap(yy) ? D29 : D28;
      8'h04, 8'h06, 8'h09, 8'h11: r = D30;
      default:                    r = D31;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/bcd_wrap_step.sv
// Combinational +/-1 on a two-digit BCD value, wrapping between lo and hi.
module bcd_wrap_step (
  input  logic [7:0] val,
  input  logic [7:0] lo,
  input  logic [7:0] hi,
  input  logic       inc,
  input  logic       dec,
  output logic [7:0] res
);

  always_comb begin
    res = val;
    if (inc && !dec) begin
      if (val >= hi) begin
        res = lo;
      end else if (val[3:0] == 4'd9) begin
        res = {val[7:4] + 4'd1, 4'd0};
      end else begin
        res = {val[7:4], val[3:0] + 4'd1};
      end
    end else if (dec && !inc) begin
      if (val <= lo) begin
        res = hi;
      end else if (val[3:0] == 4'd0) begin
        res = {val[7:4] - 4'd1, 4'd9};
      end else begin
        res = {val[7:4], val[3:0] - 4'd1};
      end
    end
  end

endmodule

// File: rtl/date_set_ctrl.sv
// Set-mode controller: freezes the date counter, edits yy/mm/dd in BCD with
// blinking field feedback, and commits the result with a one-cycle load pulse.
module date_set_ctrl
  import date_pkg::*;
#(
  parameter int         TIMEOUT_TICKS = 30,
  parameter logic [7:0] DEF_YY        = 8'h00
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_mode,
  input  logic       btn_inc,
  input  logic       btn_dec,
  input  logic       btn_abort,
  input  logic       blink_tick,
  input  logic [7:0] cur_yy,
  input  logic [7:0] cur_mm,
  input  logic [7:0] cur_dd,
  output logic       cnt_en,
  output logic       load,
  output logic [7:0] load_yy,
  output logic [7:0] load_mm,
  output logic [7:0] load_dd,
  output logic [7:0] edit_yy,
  output logic [7:0] edit_mm,
  output logic [7:0] edit_dd,
  output logic [2:0] field_blank,
  output logic       disp_override,
  output logic       disp_sel_yy
);

  localparam int TW = $clog2(TIMEOUT_TICKS + 1);

  state_e        state_q, state_d;
  logic [7:0]    yy_q, yy_d, mm_q, mm_d, dd_q, dd_d;
  logic [TW-1:0] tmo_q, tmo_d, tmo_inc;
  logic          phase_q, phase_d;
  logic          cnt_en_q, cnt_en_d;
  logic          load_q, load_d;
  logic [2:0]    blank_q, blank_d;
  logic          ovr_q, ovr_d;
  logic          sel_yy_q, sel_yy_d;

  logic [7:0]    yy_step, mm_step, dd_step, dd_max;
  logic          any_btn, edit_btn, timed_out;

  assign dd_max = maxday(mm_q, yy_q);

  bcd_wrap_step u_step_yy (
    .val(yy_q), .lo(YY_MIN), .hi(YY_MAX), .inc(btn_inc), .dec(btn_dec), .res(yy_step)
  );

  bcd_wrap_step u_step_mm (
    .val(mm_q), .lo(MM_MIN), .hi(MM_MAX), .inc(btn_inc), .dec(btn_dec), .res(mm_step)
  );

  bcd_wrap_step u_step_dd (
    .val(dd_q), .lo(DD_MIN), .hi(dd_max), .inc(btn_inc), .dec(btn_dec), .res(dd_step)
  );

  always_comb begin
    state_d   = state_q;
    yy_d      = yy_q;
    mm_d      = mm_q;
    dd_d      = dd_q;
    tmo_d     = tmo_q;
    phase_d   = phase_q;
    any_btn   = btn_mode | btn_inc | btn_dec | btn_abort;
    edit_btn  = btn_mode | btn_inc | btn_dec;
    tmo_inc   = tmo_q + 1'b1;
    timed_out = !any_btn && blink_tick && (tmo_inc == TW'(TIMEOUT_TICKS));

    case (state_q)
      RUN: begin
        tmo_d   = '0;
        phase_d = 1'b0;
        if (btn_mode) begin
          state_d = SET_YY;
          yy_d    = bcd_ok(cur_yy) ? cur_yy : DEF_YY;
          mm_d    = bcd_in_range(cur_mm, MM_MIN, MM_MAX) ? cur_mm : MM_MIN;
          dd_d    = bcd_in_range(cur_dd, DD_MIN, D31) ? cur_dd : DD_MIN;
        end
      end

      SET_YY, SET_MM, SET_DD: begin
        if (any_btn) begin
          tmo_d = '0;
        end else if (blink_tick) begin
          tmo_d = tmo_inc;
        end
        if (edit_btn) begin
          phase_d = 1'b0;
        end else if (blink_tick) begin
          phase_d = ~phase_q;
        end

        if (btn_abort || timed_out) begin
          state_d = RUN;
          tmo_d   = '0;
          phase_d = 1'b0;
        end else if (btn_mode) begin
          case (state_q)
            SET_YY: state_d = SET_MM;
            SET_MM: begin
              // Month/year are final here, so the day is clamped before it is shown.
              state_d = SET_DD;
              if (dd_q > dd_max) dd_d = dd_max;
            end
            default: state_d = COMMIT;
          endcase
        end else begin
          case (state_q)
            SET_YY:  yy_d = yy_step;
            SET_MM:  mm_d = mm_step;
            default: dd_d = dd_step;
          endcase
        end
      end

      COMMIT: begin
        state_d = RUN;
        tmo_d   = '0;
        phase_d = 1'b0;
      end

      default: begin
        state_d = RUN;
        tmo_d   = '0;
        phase_d = 1'b0;
      end
    endcase

    // Outputs are registered from the next state so they line up with it.
    cnt_en_d = (state_d == RUN);
    load_d   = (state_d == COMMIT);
    ovr_d    = (state_d == SET_YY) || (state_d == SET_MM) || (state_d == SET_DD);
    sel_yy_d = (state_d == SET_YY);
    blank_d  = 3'b000;
    case (state_d)
      SET_YY:  blank_d[FLD_YY] = phase_d;
      SET_MM:  blank_d[FLD_MM] = phase_d;
      SET_DD:  blank_d[FLD_DD] = phase_d;
      default: blank_d = 3'b000;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= RUN;
      yy_q     <= 8'h00;
      mm_q     <= 8'h01;
      dd_q     <= 8'h01;
      tmo_q    <= '0;
      phase_q  <= 1'b0;
      cnt_en_q <= 1'b1;
      load_q   <= 1'b0;
      blank_q  <= 3'b000;
      ovr_q    <= 1'b0;
      sel_yy_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      yy_q     <= yy_d;
      mm_q     <= mm_d;
      dd_q     <= dd_d;
      tmo_q    <= tmo_d;
      phase_q  <= phase_d;
      cnt_en_q <= cnt_en_d;
      load_q   <= load_d;
      blank_q  <= blank_d;
      ovr_q    <= ovr_d;
      sel_yy_q <= sel_yy_d;
    end
  end

  assign cnt_en        = cnt_en_q;
  assign load          = load_q;
  assign load_yy       = yy_q;
  assign load_mm       = mm_q;
  assign load_dd       = dd_q;
  assign edit_yy       = yy_q;
  assign edit_mm       = mm_q;
  assign edit_dd       = dd_q;
  assign field_blank   = blank_q;
  assign disp_override = ovr_q;
  assign disp_sel_yy   = sel_yy_q;

endmodule

// File: tb/tb_date_set_ctrl.sv
// Bench for date_set_ctrl: directed scenarios plus random buttons, all checked
// against a calendar-level model that keeps dates as plain integers.
module tb_date_set_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       btn_mode = 1'b0, btn_inc = 1'b0, btn_dec = 1'b0, btn_abort = 1'b0;
  logic       blink_tick = 1'b0;
  logic [7:0] cur_yy = 8'h00, cur_mm = 8'h01, cur_dd = 8'h01;
  logic       cnt_en, load, disp_override, disp_sel_yy;
  logic [7:0] load_yy, load_mm, load_dd, edit_yy, edit_mm, edit_dd;
  logic [2:0] field_blank;
  logic [54:0] act_vec;

  int vectors = 0;
  int miscompares = 0;

  localparam int M_RUN = 0, M_YY = 1, M_MM = 2, M_DD = 3, M_COMMIT = 4;
  int m_st, m_yy, m_mm, m_dd, m_tmo;
  bit m_phase, m_load;

  date_set_ctrl dut (
    .clk(clk), .rst(rst),
    .btn_mode(btn_mode), .btn_inc(btn_inc), .btn_dec(btn_dec), .btn_abort(btn_abort),
    .blink_tick(blink_tick),
    .cur_yy(cur_yy), .cur_mm(cur_mm), .cur_dd(cur_dd),
    .cnt_en(cnt_en), .load(load),
    .load_yy(load_yy), .load_mm(load_mm), .load_dd(load_dd),
    .edit_yy(edit_yy), .edit_mm(edit_mm), .edit_dd(edit_dd),
    .field_blank(field_blank), .disp_override(disp_override), .disp_sel_yy(disp_sel_yy)
  );

  always #5 clk = ~clk;

  assign act_vec = {cnt_en, load, load_yy, load_mm, load_dd, edit_yy, edit_mm, edit_dd,
                    field_blank, disp_override, disp_sel_yy};

  function automatic logic [7:0] to_bcd(input int v);
    logic [7:0] r;
    r[7:4] = 4'(v / 10);
    r[3:0] = 4'(v % 10);
    return r;
  endfunction

  function automatic int from_bcd(input logic [7:0] b);
    return int'(b[7:4]) * 10 + int'(b[3:0]);
  endfunction

  function automatic bit digits_ok(input logic [7:0] b);
    return (b[7:4] < 4'd10) && (b[3:0] < 4'd10);
  endfunction

  function automatic int days_in(input int mm, input int yy);
    int r;
    case (mm)
      2:          r = (yy % 4 == 0) ? 29 : 28;
      4, 6, 9, 11: r = 30;
      default:    r = 31;
    endcase
    return r;
  endfunction

  function automatic void model_reset();
    m_st = M_RUN; m_yy = 0; m_mm = 1; m_dd = 1; m_tmo = 0; m_phase = 0; m_load = 0;
  endfunction

  function automatic void model_go_run();
    m_st = M_RUN; m_tmo = 0; m_phase = 0;
  endfunction

  function automatic void model_step(input bit bm, input bit bi, input bit bd,
                                     input bit ba, input bit bt);
    int md, delta, v;
    m_load = 0;
    if (m_st == M_RUN) begin
      if (bm) begin
        m_yy = digits_ok(cur_yy) ? from_bcd(cur_yy) : 0;
        v = from_bcd(cur_mm);
        m_mm = (digits_ok(cur_mm) && v >= 1 && v <= 12) ? v : 1;
        v = from_bcd(cur_dd);
        m_dd = (digits_ok(cur_dd) && v >= 1 && v <= 31) ? v : 1;
        m_st = M_YY; m_tmo = 0; m_phase = 0;
      end
    end else if (m_st == M_COMMIT) begin
      model_go_run();
    end else if (ba) begin
      model_go_run();
    end else if (bm) begin
      m_phase = 0; m_tmo = 0;
      if (m_st == M_YY) m_st = M_MM;
      else if (m_st == M_MM) begin
        m_st = M_DD;
        md = days_in(m_mm, m_yy);
        if (m_dd > md) m_dd = md;
      end else begin
        m_st = M_COMMIT; m_load = 1;
      end
    end else if (bi || bd) begin
      m_phase = 0; m_tmo = 0;
      if (bi != bd) begin
        delta = bi ? 1 : -1;
        if (m_st == M_YY) m_yy = (m_yy + delta + 100) % 100;
        else if (m_st == M_MM) m_mm = (m_mm - 1 + delta + 12) % 12 + 1;
        else begin
          md = days_in(m_mm, m_yy);
          m_dd = (m_dd - 1 + delta + md) % md + 1;
        end
      end
    end else if (bt) begin
      m_tmo++;
      m_phase = !m_phase;
      if (m_tmo >= 30) model_go_run();
    end
  endfunction

  function automatic logic [54:0] model_vec();
    logic [23:0] e;
    logic [2:0]  fb;
    logic        in_set;
    e = {to_bcd(m_yy), to_bcd(m_mm), to_bcd(m_dd)};
    fb = 3'b000;
    if (m_st == M_YY) fb = {m_phase, 2'b00};
    if (m_st == M_MM) fb = {1'b0, m_phase, 1'b0};
    if (m_st == M_DD) fb = {2'b00, m_phase};
    in_set = (m_st == M_YY) || (m_st == M_MM) || (m_st == M_DD);
    return {(m_st == M_RUN), m_load, e, e, fb, in_set, (m_st == M_YY)};
  endfunction

  task automatic step(input bit bm, input bit bi, input bit bd, input bit ba, input bit bt);
    @(negedge clk);
    btn_mode = bm; btn_inc = bi; btn_dec = bd; btn_abort = ba; blink_tick = bt;
    @(posedge clk);
    if (rst) model_reset();
    else model_step(bm, bi, bd, ba, bt);
    #1;
    btn_mode = 0; btn_inc = 0; btn_dec = 0; btn_abort = 0; blink_tick = 0;
  endtask

  task automatic test_reset();
    #1 rst = 1'b1;
    #1;
    model_reset();
    vectors++;
    if (act_vec !== model_vec()) begin
      miscompares++; $display("[TB] FAIL reset_async: act=%h exp=%h", act_vec, model_vec());
    end
    vectors++;
    if ({cnt_en, load, edit_yy, edit_mm, edit_dd, field_blank, disp_override, disp_sel_yy}
        !== {1'b1, 1'b0, 8'h00, 8'h01, 8'h01, 3'b000, 1'b0, 1'b0}) begin
      miscompares++;
      $display("[TB] FAIL reset_values: cnt_en=%b load=%b edit=%h/%h/%h blank=%b ovr=%b sel=%b",
               cnt_en, load, edit_yy, edit_mm, edit_dd, field_blank, disp_override, disp_sel_yy);
    end
    step(0, 0, 0, 0, 0);
    step(1, 1, 0, 0, 1);
    rst = 1'b0;
    step(0, 1, 1, 1, 1);
    vectors++;
    if (act_vec !== model_vec()) begin
      miscompares++; $display("[TB] FAIL reset_release: act=%h exp=%h", act_vec, model_vec());
    end
  endtask

  task automatic test_basic_commit();
    cur_yy = 8'h19; cur_mm = 8'h04; cur_dd = 8'h10;
    step(1, 0, 0, 0, 0);
    vectors++;
    if ({cnt_en, edit_yy, disp_sel_yy, disp_override} !== {1'b0, 8'h19, 1'b1, 1'b1}) begin
      miscompares++;
      $display("[TB] FAIL capture: cnt_en=%b yy=%h sel=%b ovr=%b, want 0 19 1 1",
               cnt_en, edit_yy, disp_sel_yy, disp_override);
    end
    cur_yy = 8'h55; cur_mm = 8'h07; cur_dd = 8'h03;
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 0, 0, 0);
      vectors++;
      if (act_vec !== model_vec()) begin
        miscompares++; $display("[TB] FAIL yy_inc%0d: act=%h exp=%h", i, act_vec, model_vec());
      end
    end
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    vectors++;
    if (act_vec !== model_vec()) begin
      miscompares++; $display("[TB] FAIL to_set_dd: act=%h exp=%h", act_vec, model_vec());
    end
    step(1, 0, 0, 0, 0);
    vectors++;
    if ({load, cnt_en, load_yy, load_mm, load_dd} !== {1'b1, 1'b0, 8'h22, 8'h04, 8'h10}) begin
      miscompares++;
      $display("[TB] FAIL commit: load=%b cnt_en=%b ld=%h/%h/%h, want 1 0 22/04/10",
               load, cnt_en, load_yy, load_mm, load_dd);
    end
    step(0, 0, 0, 0, 0);
    vectors++;
    if ({load, cnt_en, disp_override} !== 3'b010 || act_vec !== model_vec()) begin
      miscompares++;
      $display("[TB] FAIL after_commit: load=%b cnt_en=%b ovr=%b, want 0 1 0",
               load, cnt_en, disp_override);
    end
  endtask

  task automatic test_leap();
    cur_yy = 8'h24; cur_mm = 8'h01; cur_dd = 8'h31;
    step(1, 0, 0, 0, 0); step(1, 0, 0, 0, 0); step(0, 1, 0, 0, 0);
    vectors++;
    if (edit_mm !== 8'h02) begin
      miscompares++; $display("[TB] FAIL mm_inc: edit_mm=%h want 02", edit_mm);
    end
    step(1, 0, 0, 0, 0);
    vectors++;
    if (edit_dd !== 8'h29) begin
      miscompares++; $display("[TB] FAIL leap_clamp: edit_dd=%h want 29", edit_dd);
    end
    step(0, 1, 0, 0, 0);
    vectors++;
    if (edit_dd !== 8'h01) begin
      miscompares++; $display("[TB] FAIL leap_wrap: edit_dd=%h want 01", edit_dd);
    end
    step(0, 0, 0, 1, 0);
    cur_yy = 8'h23;
    step(1, 0, 0, 0, 0); step(1, 0, 0, 0, 0); step(0, 1, 0, 0, 0); step(1, 0, 0, 0, 0);
    vectors++;
    if (edit_dd !== 8'h28 || act_vec !== model_vec()) begin
      miscompares++; $display("[TB] FAIL nonleap_clamp: edit_dd=%h want 28", edit_dd);
    end
    step(0, 0, 0, 1, 0);
  endtask

  task automatic test_wrap();
    cur_yy = 8'h99; cur_mm = 8'h12; cur_dd = 8'h30;
    step(1, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    vectors++;
    if (edit_yy !== 8'h00) begin
      miscompares++; $display("[TB] FAIL yy_wrap_up: edit_yy=%h want 00", edit_yy);
    end
    step(0, 0, 1, 0, 0);
    vectors++;
    if (edit_yy !== 8'h99) begin
      miscompares++; $display("[TB] FAIL yy_wrap_dn: edit_yy=%h want 99", edit_yy);
    end
    step(1, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    vectors++;
    if (edit_mm !== 8'h01) begin
      miscompares++; $display("[TB] FAIL mm_wrap_up: edit_mm=%h want 01", edit_mm);
    end
    for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    vectors++;
    if ({edit_mm, edit_dd} !== {8'h04, 8'h01}) begin
      miscompares++; $display("[TB] FAIL dd_wrap_up: mm/dd=%h/%h want 04/01", edit_mm, edit_dd);
    end
    step(0, 0, 1, 0, 0);
    vectors++;
    if (edit_dd !== 8'h30 || act_vec !== model_vec()) begin
      miscompares++; $display("[TB] FAIL dd_wrap_dn: edit_dd=%h want 30", edit_dd);
    end
    step(0, 0, 0, 1, 0);
  endtask

  task automatic test_abort();
    cur_yy = 8'h31; cur_mm = 8'h08; cur_dd = 8'h17;
    step(1, 0, 0, 0, 0); step(1, 0, 0, 0, 0); step(0, 0, 1, 0, 0);
    step(0, 0, 0, 1, 0);
    vectors++;
    if ({cnt_en, load, disp_override, edit_mm} !== {1'b1, 1'b0, 1'b0, 8'h07}) begin
      miscompares++;
      $display("[TB] FAIL abort: cnt_en=%b load=%b ovr=%b mm=%h, want 1 0 0 07",
               cnt_en, load, disp_override, edit_mm);
    end
    step(0, 0, 0, 0, 0);
    vectors++;
    if (act_vec !== model_vec()) begin
      miscompares++; $display("[TB] FAIL abort_idle: act=%h exp=%h", act_vec, model_vec());
    end
  endtask

  task automatic test_timeout();
    cur_yy = 8'h20; cur_mm = 8'h02; cur_dd = 8'h15;
    step(1, 0, 0, 0, 0); step(1, 0, 0, 0, 0); step(1, 0, 0, 0, 0);
    for (int i = 1; i <= 29; i++) begin
      step(0, 0, 0, 0, 1);
      vectors++;
      if (act_vec !== model_vec()) begin
        miscompares++; $display("[TB] FAIL tick_a%0d: act=%h exp=%h", i, act_vec, model_vec());
      end
    end
    step(0, 1, 1, 0, 0);
    vectors++;
    if ({disp_override, edit_dd, field_blank} !== {1'b1, 8'h15, 3'b000}) begin
      miscompares++;
      $display("[TB] FAIL restart: ovr=%b dd=%h blank=%b want 1 15 000",
               disp_override, edit_dd, field_blank);
    end
    for (int i = 1; i <= 29; i++) step(0, 0, 0, 0, 1);
    vectors++;
    if (disp_override !== 1'b1 || cnt_en !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL tick_29: ovr=%b cnt_en=%b want 1 0", disp_override, cnt_en);
    end
    step(0, 0, 0, 0, 1);
    vectors++;
    if ({cnt_en, load, disp_override} !== 3'b100 || act_vec !== model_vec()) begin
      miscompares++;
      $display("[TB] FAIL timeout: cnt_en=%b load=%b ovr=%b want 1 0 0",
               cnt_en, load, disp_override);
    end
  endtask

  task automatic test_priority();
    cur_yy = 8'h45; cur_mm = 8'h07; cur_dd = 8'h20;
    step(1, 0, 0, 0, 0);
    step(0, 1, 1, 0, 0);
    vectors++;
    if (edit_yy !== 8'h45) begin
      miscompares++; $display("[TB] FAIL inc_dec: edit_yy=%h want 45", edit_yy);
    end
    step(1, 1, 0, 0, 0);
    vectors++;
    if ({edit_yy, disp_sel_yy, disp_override} !== {8'h45, 1'b0, 1'b1}) begin
      miscompares++;
      $display("[TB] FAIL mode_inc: yy=%h sel=%b ovr=%b want 45 0 1",
               edit_yy, disp_sel_yy, disp_override);
    end
    step(1, 0, 0, 1, 0);
    vectors++;
    if ({cnt_en, load} !== 2'b10 || act_vec !== model_vec()) begin
      miscompares++; $display("[TB] FAIL abort_mode: cnt_en=%b load=%b want 1 0", cnt_en, load);
    end
  endtask

  task automatic test_blink();
    logic [2:0] want [4];
    want[0] = 3'b010; want[1] = 3'b000; want[2] = 3'b010; want[3] = 3'b000;
    cur_yy = 8'h12; cur_mm = 8'h1F; cur_dd = 8'h05;
    step(1, 0, 0, 0, 0);
    vectors++;
    if (edit_mm !== 8'h01) begin
      miscompares++; $display("[TB] FAIL sanitise_mm: edit_mm=%h want 01", edit_mm);
    end
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 0, 1);
      vectors++;
      if (field_blank !== want[i]) begin
        miscompares++;
        $display("[TB] FAIL blink%0d: field_blank=%b want %b", i, field_blank, want[i]);
      end
    end
    step(0, 1, 0, 0, 0);
    vectors++;
    if ({field_blank, edit_mm} !== {want[3], 8'h02}) begin
      miscompares++;
      $display("[TB] FAIL blink_inc: blank=%b mm=%h want 000 02", field_blank, edit_mm);
    end
    step(0, 0, 0, 1, 0);
  endtask

  task automatic test_rst_mid_edit();
    cur_yy = 8'h10; cur_mm = 8'h03; cur_dd = 8'h31;
    step(1, 0, 0, 0, 0); step(1, 0, 0, 0, 0); step(1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1);
    #2 rst = 1'b1;
    model_reset();
    #1;
    vectors++;
    if ({cnt_en, load, edit_yy, edit_mm, edit_dd, field_blank, disp_override, disp_sel_yy}
        !== {1'b1, 1'b0, 8'h00, 8'h01, 8'h01, 3'b000, 1'b0, 1'b0}) begin
      miscompares++;
      $display("[TB] FAIL rst_mid: cnt_en=%b load=%b edit=%h/%h/%h blank=%b ovr=%b",
               cnt_en, load, edit_yy, edit_mm, edit_dd, field_blank, disp_override);
    end
    step(1, 0, 0, 0, 0);
    rst = 1'b0;
    step(0, 0, 0, 0, 0);
    vectors++;
    if (act_vec !== model_vec()) begin
      miscompares++; $display("[TB] FAIL rst_release: act=%h exp=%h", act_vec, model_vec());
    end
  endtask

  task automatic test_random();
    bit bm, bi, bd, ba, bt;
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        cur_yy = 8'($urandom); cur_mm = 8'($urandom); cur_dd = 8'($urandom);
      end else begin
        cur_yy = to_bcd($urandom_range(0, 99));
        cur_mm = to_bcd($urandom_range(1, 12));
        cur_dd = to_bcd($urandom_range(1, 31));
      end
      bm = ($urandom_range(0, 99) < 8);
      bi = ($urandom_range(0, 99) < 25);
      bd = ($urandom_range(0, 99) < 25);
      ba = ($urandom_range(0, 99) < 2);
      bt = ($urandom_range(0, 99) < 20);
      step(bm, bi, bd, ba, bt);
      vectors++;
      if (act_vec !== model_vec()) begin
        miscompares++;
        $display("[TB] FAIL random%0d: act=%h exp=%h", n, act_vec, model_vec());
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_commit();
    test_leap();
    test_wrap();
    test_abort();
    test_timeout();
    test_priority();
    test_blink();
    test_rst_mid_edit();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
